// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage core: load-use stall, branch flush,
// data-memory wait freeze with timeout trap, and saturating hazard statistics.
module hazard_control_unit #(
    parameter int unsigned MEM_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IFID_RS1,
    input  logic [4:0]       IFID_RS2,
    input  logic             IFID_UsesRS2,
    input  logic [4:0]       IDEXE_RD,
    input  logic             IDEXE_MemRead,
    input  logic             Branch_Taken,
    input  logic             EXEMEM_MemReq,
    input  logic             Dmem_Ready,
    output logic             PC_Write,
    output logic             IFID_Write,
    output logic             IFID_Flush,
    output logic             IDEXE_Flush,
    output logic             Pipe_Hold,
    output logic             Mem_Error,
    output logic [CNT_W-1:0] LoadUse_Cnt,
    output logic [CNT_W-1:0] MemWait_Cnt,
    output logic [CNT_W-1:0] Flush_Cnt
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [1:0] {StRun, StMemWait, StError} state_e;

    state_e           state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d;
    logic [CNT_W-1:0] mw_cnt_q, mw_cnt_d;
    logic [CNT_W-1:0] fl_cnt_q, fl_cnt_d;

    logic lu, mw;
    logic lu_act, mw_act, br_act;

    assign lu = IDEXE_MemRead && (IDEXE_RD != 5'd0) &&
                ((IFID_RS1 == IDEXE_RD) || (IFID_UsesRS2 && (IFID_RS2 == IDEXE_RD)));
    assign mw = EXEMEM_MemReq && !Dmem_Ready;

    // Output decode; priority ERROR > mw > branch > load-use > normal.
    always_comb begin
        PC_Write    = 1'b1;
        IFID_Write  = 1'b1;
        IFID_Flush  = 1'b0;
        IDEXE_Flush = 1'b0;
        Pipe_Hold   = 1'b0;
        Mem_Error   = 1'b0;
        lu_act      = 1'b0;
        mw_act      = 1'b0;
        br_act      = 1'b0;
        if (state_q == StError) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            Pipe_Hold  = 1'b1;
            Mem_Error  = 1'b1;
        end else if (mw) begin
            PC_Write   = 1'b0;
            IFID_Write = 1'b0;
            Pipe_Hold  = 1'b1;
            mw_act     = 1'b1;
        end else if (Branch_Taken) begin
            IFID_Flush  = 1'b1;
            IDEXE_Flush = 1'b1;
            br_act      = 1'b1;
        end else if (lu) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEXE_Flush = 1'b1;
            lu_act      = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StRun: begin
                if (mw) begin
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end
            end
            StMemWait: begin
                if (!mw) begin
                    state_d = StRun;
                end else if (wait_q == WaitW'(MEM_TIMEOUT)) begin
                    state_d = StError;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StError: state_d = StError;
            default: state_d = StRun;
        endcase
    end

    // Statistics saturate at all-ones instead of wrapping.
    always_comb begin
        lu_cnt_d = lu_cnt_q;
        mw_cnt_d = mw_cnt_q;
        fl_cnt_d = fl_cnt_q;
        if (lu_act && (lu_cnt_q != {CNT_W{1'b1}})) lu_cnt_d = lu_cnt_q + CNT_W'(1);
        if (mw_act && (mw_cnt_q != {CNT_W{1'b1}})) mw_cnt_d = mw_cnt_q + CNT_W'(1);
        if (br_act && (fl_cnt_q != {CNT_W{1'b1}})) fl_cnt_d = fl_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= StRun;
            wait_q   <= '0;
            lu_cnt_q <= '0;
            mw_cnt_q <= '0;
            fl_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            lu_cnt_q <= lu_cnt_d;
            mw_cnt_q <= mw_cnt_d;
            fl_cnt_q <= fl_cnt_d;
        end
    end

    assign LoadUse_Cnt = lu_cnt_q;
    assign MemWait_Cnt = mw_cnt_q;
    assign Flush_Cnt   = fl_cnt_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: vector table for output decode plus
// sequences for stall length, memory wait, timeout, saturation and async reset.
module tb_hazard_control_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       uses_rs2 = 1'b0, mem_read = 1'b0, branch = 1'b0;
    logic       mem_req = 1'b0, dmem_ready = 1'b0;

    logic        pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold, mem_error;
    logic [15:0] lu_cnt, mw_cnt, fl_cnt;
    logic        b_pc_write, b_ifid_write, b_ifid_flush, b_idexe_flush, b_pipe_hold, b_mem_error;
    logic [1:0]  b_lu_cnt, b_mw_cnt, b_fl_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst),
        .IFID_RS1(rs1), .IFID_RS2(rs2), .IFID_UsesRS2(uses_rs2),
        .IDEXE_RD(rd), .IDEXE_MemRead(mem_read), .Branch_Taken(branch),
        .EXEMEM_MemReq(mem_req), .Dmem_Ready(dmem_ready),
        .PC_Write(pc_write), .IFID_Write(ifid_write), .IFID_Flush(ifid_flush),
        .IDEXE_Flush(idexe_flush), .Pipe_Hold(pipe_hold), .Mem_Error(mem_error),
        .LoadUse_Cnt(lu_cnt), .MemWait_Cnt(mw_cnt), .Flush_Cnt(fl_cnt)
    );

    hazard_control_unit #(.MEM_TIMEOUT(4), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst),
        .IFID_RS1(rs1), .IFID_RS2(rs2), .IFID_UsesRS2(uses_rs2),
        .IDEXE_RD(rd), .IDEXE_MemRead(mem_read), .Branch_Taken(branch),
        .EXEMEM_MemReq(mem_req), .Dmem_Ready(dmem_ready),
        .PC_Write(b_pc_write), .IFID_Write(b_ifid_write), .IFID_Flush(b_ifid_flush),
        .IDEXE_Flush(b_idexe_flush), .Pipe_Hold(b_pipe_hold), .Mem_Error(b_mem_error),
        .LoadUse_Cnt(b_lu_cnt), .MemWait_Cnt(b_mw_cnt), .Flush_Cnt(b_fl_cnt)
    );

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       uses_rs2, mem_read, branch, mem_req, dmem_ready;
        logic       pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance one full cycle; returns just after the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rs1 = '0; rs2 = '0; rd = '0;
        uses_rs2 = 1'b0; mem_read = 1'b0; branch = 1'b0;
        mem_req = 1'b0; dmem_ready = 1'b0;
    endtask

    // Assert reset between edges and check that it takes effect before any clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        check({tag, "_lu_cnt"}, 32'(lu_cnt), 0);
        check({tag, "_mw_cnt"}, 32'(mw_cnt), 0);
        check({tag, "_fl_cnt"}, 32'(fl_cnt), 0);
        check({tag, "_mem_error"}, 32'(mem_error), 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    function automatic vec_t mk(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] d,
                                input logic u, input logic m, input logic b, input logic q,
                                input logic rdy, input logic [4:0] exp);
        vec_t v;
        v.rs1 = r1; v.rs2 = r2; v.rd = d;
        v.uses_rs2 = u; v.mem_read = m; v.branch = b; v.mem_req = q; v.dmem_ready = rdy;
        {v.pc_write, v.ifid_write, v.ifid_flush, v.idexe_flush, v.pipe_hold} = exp;
        return v;
    endfunction

    initial begin
        // expected = {pc_write, ifid_write, ifid_flush, idexe_flush, pipe_hold}
        vecs[0] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11000); // idle
        vecs[1] = mk(5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, 5'b00010); // rs1 load-use
        vecs[2] = mk(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, 0, 5'b11000); // rd = x0
        vecs[3] = mk(5'd0, 5'd7, 5'd7, 1, 1, 0, 0, 0, 5'b00010); // rs2 used
        vecs[4] = mk(5'd0, 5'd7, 5'd7, 0, 1, 0, 0, 0, 5'b11000); // rs2 not used
        vecs[5] = mk(5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0, 5'b11000); // not a load
        vecs[6] = mk(5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, 5'b11110); // branch beats lu
        vecs[7] = mk(5'd0, 5'd0, 5'd0, 0, 0, 1, 1, 1, 5'b11110); // ready same cycle
        vecs[8] = mk(5'd5, 5'd0, 5'd5, 0, 1, 1, 1, 0, 5'b00001); // mw beats all
        vecs[9] = mk(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 5'b11000); // back to normal

        // Reset state
        tick();
        #1;
        check("rst_pc_write", 32'(pc_write), 1);
        check("rst_pipe_hold", 32'(pipe_hold), 0);
        check("rst_mem_error", 32'(mem_error), 0);
        check("rst_lu_cnt", 32'(lu_cnt), 0);
        check("rst_mw_cnt", 32'(mw_cnt), 0);
        check("rst_fl_cnt", 32'(fl_cnt), 0);
        @(negedge clk);
        rst = 1'b1;

        // Output decode table
        for (int i = 0; i < 10; i++) begin
            rs1 = vecs[i].rs1; rs2 = vecs[i].rs2; rd = vecs[i].rd;
            uses_rs2 = vecs[i].uses_rs2; mem_read = vecs[i].mem_read;
            branch = vecs[i].branch; mem_req = vecs[i].mem_req;
            dmem_ready = vecs[i].dmem_ready;
            #1;
            check($sformatf("vec%0d_pc_write", i), 32'(pc_write), 32'(vecs[i].pc_write));
            check($sformatf("vec%0d_ifid_write", i), 32'(ifid_write), 32'(vecs[i].ifid_write));
            check($sformatf("vec%0d_ifid_flush", i), 32'(ifid_flush), 32'(vecs[i].ifid_flush));
            check($sformatf("vec%0d_idexe_flush", i), 32'(idexe_flush),
                  32'(vecs[i].idexe_flush));
            check($sformatf("vec%0d_pipe_hold", i), 32'(pipe_hold), 32'(vecs[i].pipe_hold));
            tick();
        end
        clear_inputs();
        async_reset("post_table");

        // Load-use: one stall cycle, then the bubble sits in EXE
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5;
        tick();
        mem_read = 1'b0; rd = 5'd0;
        #1;
        check("lu_after_pc_write", 32'(pc_write), 1);
        check("lu_after_idexe_flush", 32'(idexe_flush), 0);
        check("lu_cnt_one", 32'(lu_cnt), 1);
        mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0;
        tick();
        check("lu_x0_cnt", 32'(lu_cnt), 1);
        clear_inputs();
        async_reset("post_lu");

        // Branch wins over load-use
        mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; branch = 1'b1;
        tick();
        clear_inputs();
        #1;
        check("br_fl_cnt", 32'(fl_cnt), 1);
        check("br_lu_cnt", 32'(lu_cnt), 0);
        async_reset("post_br");

        // Memory wait of 3 cycles, with a branch pulse mid-wait
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) branch = 1'b1;
            #1;
            check($sformatf("mw%0d_pipe_hold", i), 32'(pipe_hold), 1);
            check($sformatf("mw%0d_pc_write", i), 32'(pc_write), 0);
            check($sformatf("mw%0d_ifid_flush", i), 32'(ifid_flush), 0);
            tick();
            branch = 1'b0;
        end
        dmem_ready = 1'b1;
        #1;
        check("mw_done_pipe_hold", 32'(pipe_hold), 0);
        check("mw_done_pc_write", 32'(pc_write), 1);
        tick();
        clear_inputs();
        #1;
        check("mw_cnt_three", 32'(mw_cnt), 3);
        check("mw_fl_cnt", 32'(fl_cnt), 0);

        // Timeout: wait counter must restart at 1, trap after the 5th stall cycle
        mem_req = 1'b1; dmem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("to%0d_mem_error", i), 32'(mem_error), 0);
            check($sformatf("to%0d_pipe_hold", i), 32'(pipe_hold), 1);
            tick();
        end
        #1;
        check("to_mem_error_set", 32'(mem_error), 1);
        dmem_ready = 1'b1; mem_req = 1'b0; branch = 1'b1;
        tick();
        tick();
        check("to_sticky_mem_error", 32'(mem_error), 1);
        check("to_err_pc_write", 32'(pc_write), 0);
        check("to_err_ifid_flush", 32'(ifid_flush), 0);
        check("to_err_pipe_hold", 32'(pipe_hold), 1);
        check("to_err_fl_cnt", 32'(fl_cnt), 0);
        check("to_mw_cnt", 32'(mw_cnt), 8);
        clear_inputs();
        async_reset("post_err");
        #1;
        check("post_err_pc_write", 32'(pc_write), 1);

        // Saturation: five load-use events
        for (int i = 0; i < 5; i++) begin
            mem_read = 1'b1; rd = 5'd3; rs1 = 5'd3;
            tick();
            clear_inputs();
            tick();
        end
        check("sat_lu_cnt_w2", 32'(b_lu_cnt), 3);
        check("sat_lu_cnt_w16", 32'(lu_cnt), 5);

        // Reset asserted in the middle of a memory wait
        mem_req = 1'b1; dmem_ready = 1'b0;
        tick();
        tick();
        async_reset("mid_wait");
        check("mid_wait_sat_lu_cnt", 32'(b_lu_cnt), 0);
        clear_inputs();
        #1;
        check("mid_wait_pc_write", 32'(pc_write), 1);
        check("mid_wait_pipe_hold", 32'(pipe_hold), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Pipeline hazard controller for the 5-stage core; handles the hazards that operand forwarding cannot resolve.
- Load-use hazard: stalls IF/ID and inserts a bubble into ID/EX.
- Taken branch (resolved in EXE): flushes IF/ID and ID/EX.
- Variable-latency data memory in MEM: freezes the whole pipeline, enforces a wait timeout and keeps saturating hazard statistics counters.

Parameters:
- MEM_TIMEOUT, 64, max consecutive cycles in MEM_WAIT before the error trap.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- IFID_RS1  input  5  rs1 of instruction in ID.
- IFID_RS2  input  5  rs2 of instruction in ID.
- IFID_UsesRS2  input  1  ID instruction reads rs2 (R/S/B type).
- IDEXE_RD  input  5  rd of instruction in EXE.
- IDEXE_MemRead  input  1  EXE instruction is a load.
- Branch_Taken  input  1  EXE branch/jump resolved taken.
- EXEMEM_MemReq  input  1  MEM instruction accesses data memory.
- Dmem_Ready  input  1  data memory completes access this cycle.
- PC_Write  output  1  PC register enable.
- IFID_Write  output  1  IF/ID register enable.
- IFID_Flush  output  1  IF/ID loads NOP.
- IDEXE_Flush  output  1  ID/EX loads bubble (control zeroed).
- Pipe_Hold  output  1  freeze ID/EX, EX/MEM, MEM/WB.
- Mem_Error  output  1  sticky timeout flag.
- LoadUse_Cnt  output  CNT_W  load-use stall cycles.
- MemWait_Cnt  output  CNT_W  memory wait cycles.
- Flush_Cnt  output  CNT_W  branch flush events.

Behaviour:
- Combinational terms:
  - lu = IDEXE_MemRead && IDEXE_RD!=0 && (IFID_RS1==IDEXE_RD || (IFID_UsesRS2 && IFID_RS2==IDEXE_RD)).
  - mw = EXEMEM_MemReq && !Dmem_Ready.
- States: RUN, MEM_WAIT, ERROR. Reset enters RUN; all counters 0, Mem_Error 0.
- Outputs are combinational from state and inputs. Priority: ERROR > mw > Branch_Taken > lu > normal.
- ERROR: PC_Write=0, IFID_Write=0, Pipe_Hold=1, both flushes 0, Mem_Error=1. Left only by reset.
- mw in RUN or MEM_WAIT:
  - PC_Write=0, IFID_Write=0, Pipe_Hold=1, flushes 0.
  - Branch_Taken and lu are ignored; upstream state is frozen, so they re-evaluate when mw drops.
- Branch_Taken (no mw): PC_Write=1, IFID_Write=1, IFID_Flush=1, IDEXE_Flush=1, Pipe_Hold=0. Any lu is discarded.
- lu (no mw, no branch): PC_Write=0, IFID_Write=0, IDEXE_Flush=1, Pipe_Hold=0.
  - Exactly 1 stall cycle. The next cycle the bubble sits in EXE, so lu clears and the load result is forwarded from MEM/WB.
- Normal: PC_Write=1, IFID_Write=1, all other control outputs 0.
- Transitions:
  - RUN→MEM_WAIT when mw; wait counter ← 1.
  - MEM_WAIT→RUN when !mw.
  - MEM_WAIT: wait counter increments each cycle mw holds.
  - MEM_WAIT→ERROR when mw and wait counter==MEM_TIMEOUT; the cycle count including the entry cycle exceeds MEM_TIMEOUT.
  - Dmem_Ready in the same cycle as the request: no stall, state stays RUN.
  - Wait counter width is clog2(MEM_TIMEOUT+1).
- Statistics counters update on rising clk_i and saturate at 2^CNT_W-1 (no wrap):
  - LoadUse_Cnt: +1 per cycle the lu output case is active.
  - MemWait_Cnt: +1 per cycle mw is active in RUN or MEM_WAIT.
  - Flush_Cnt: +1 per cycle the Branch_Taken case is active.
  - No counter increments in ERROR.
- Reset asserted mid-wait returns immediately (asynchronously) to RUN with counters 0.

Test Plan:
- Load-use:
  - Stimulus: IDEXE_MemRead=1, IDEXE_RD=5, IFID_RS1=5, other inputs 0.
  - Response: PC_Write=0, IFID_Write=0, IDEXE_Flush=1 for one cycle; LoadUse_Cnt=1.
  - Repeat with IDEXE_RD=0 → no stall.
- rs2 gating:
  - Stimulus: IDEXE_MemRead=1, IDEXE_RD=7, IFID_RS2=7.
  - Response: stall with IFID_UsesRS2=1; no stall with IFID_UsesRS2=0.
- Branch beats load-use:
  - Stimulus: Branch_Taken=1 with the lu condition true.
  - Response: IFID_Flush=1, IDEXE_Flush=1, PC_Write=1; Flush_Cnt=1; LoadUse_Cnt=0.
- Memory wait:
  - Stimulus: EXEMEM_MemReq=1, Dmem_Ready=0 for 3 cycles, then 1.
  - Response: Pipe_Hold=1 and PC_Write=0 for 3 cycles; state returns to RUN; MemWait_Cnt=3.
  - A Branch_Taken pulse during the wait produces no flush.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, EXEMEM_MemReq=1, Dmem_Ready held 0.
  - Response: Mem_Error rises after the 5th stall cycle and stays set with Dmem_Ready=1; cleared only by rst_i=0.
- Saturation and async reset:
  - Stimulus: CNT_W=2, 5 load-use events.
  - Response: LoadUse_Cnt=3.
  - Pulse rst_i low between clock edges → all counters read 0 immediately and state is RUN.
